// File: rtl/seg_disp_sched_pkg.sv
// seg_disp_pkg: shared constants and types for the 7-segment display scheduler.
//   NREQ     - number of display requesters
//   DATA_W   - width of one display frame
//   state_e  - scheduler FSM states
//   MODE_*   - disp_mode encodings understood by the segment driver
package seg_disp_pkg;

    localparam int NREQ   = 4;
    localparam int DATA_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    localparam logic MODE_HEX = 1'b0;   // low 32 bits shown as 8 hex digits
    localparam logic MODE_RAW = 1'b1;   // 8 raw segment bytes

endpackage

// File: rtl/seg_disp_sched_if.sv
// seg_disp_sched_if: requester-side frame handshake.
//   req_valid[i]  - requester i has a frame pending (held until accepted)
//   req_data      - frames, requester i in bits [DATA_W*i +: DATA_W]
//   req_mode[i]   - display mode of requester i's frame
//   req_ready[i]  - one-hot accept strobe from the scheduler
// master: requester side; slave: scheduler side.
interface seg_disp_sched_if #(
    parameter int NREQ   = seg_disp_pkg::NREQ,
    parameter int DATA_W = seg_disp_pkg::DATA_W
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_mode;
    logic [NREQ-1:0]        req_ready;

    modport master (output req_valid, req_data, req_mode, input  req_ready);
    modport slave  (input  req_valid, req_data, req_mode, output req_ready);
endinterface

// File: rtl/seg_disp_sched_rr_arb4.sv
// rr_arb4: 4-way round-robin pick, purely combinational.
//   req[3:0]       - requesting lanes
//   last[1:0]      - previous winner; search starts at last+1 (mod 4)
//   grant[3:0]     - one-hot winner (zero when nothing requests)
//   grant_idx[1:0] - binary index of the winner
//   any            - at least one request present
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       any
);
    logic [1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        // 2-bit wraparound on idx gives the mod-4 rotation for free
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
        if (any) grant = 4'b0001 << grant_idx;
    end
endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: picks one of NREQ requesters round-robin and holds its frame
// on the 7-segment driver for at least dwell_cycles clocks. Requester 0 is
// urgent and may cut into another requester's dwell.
//   clk, rstn     - clock, async active-low reset
//   rq            - requester handshake (slave side)
//   dwell_cycles  - hold time, sampled at accept (0 behaves as 1)
//   disp_data     - registered frame to the segment driver
//   disp_mode     - registered mode (MODE_HEX / MODE_RAW)
//   disp_owner    - registered index of the requester being shown
//   busy          - registered, high while in SHOW
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rstn,
    seg_disp_sched_if.slave    rq,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic [DATA_W-1:0]  disp_data,
    output logic               disp_mode,
    output logic [1:0]         disp_owner,
    output logic               busy
);
    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q;
    logic [1:0]         last_q;

    logic [3:0]         arb_grant;
    logic [1:0]         arb_idx;
    logic               arb_any;

    logic [NREQ-1:0]    ready_c;
    logic [1:0]         take_idx;
    logic               take;

    rr_arb4 u_arb (
        .req       (rq.req_valid),
        .last      (last_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Accept decision. Gated by rstn so nothing is accepted while in reset.
    always_comb begin
        ready_c  = '0;
        take_idx = '0;
        if (rstn) begin
            if (state_q == IDLE) begin
                if (arb_any) begin
                    ready_c  = arb_grant;
                    take_idx = arb_idx;
                end
            end else if (rq.req_valid[0] && disp_owner != 2'd0) begin
                // urgent requester 0 preempts anyone else's dwell
                ready_c  = NREQ'(1);
                take_idx = 2'd0;
            end
        end
        take = |ready_c;
    end

    assign rq.req_ready = ready_c;

    // Next state: a transfer always lands in SHOW, which also covers a
    // preemption on the same cycle the dwell would have expired.
    always_comb begin
        state_d = state_q;
        if (take)
            state_d = SHOW;
        else if (state_q == SHOW && cnt_q == CNT_ONE)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_data  <= '0;
            disp_mode  <= MODE_HEX;
            disp_owner <= 2'd0;
            busy       <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 2'd3;     // requester 0 wins first
        end else begin
            busy <= (state_d == SHOW);
            if (take) begin
                disp_data  <= rq.req_data[int'(take_idx)*DATA_W +: DATA_W];
                disp_mode  <= rq.req_mode[take_idx];
                disp_owner <= take_idx;
                last_q     <= take_idx;
                cnt_q      <= (dwell_cycles == '0) ? CNT_ONE : dwell_cycles;
            end else if (state_q == SHOW) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end
endmodule

// File: doc/seg_disp_sched.md
SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of display requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter DWELL_W, default 24, giving the width of the dwell counter.
REQ-003 The block SHALL have port clk  input  1  system clock.
REQ-004 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester frame valid.
REQ-006 The block SHALL have port req_data  input  NREQ*64  per-requester frame; requester i occupies bits [64*i+63:64*i].
REQ-007 The block SHALL have port req_mode  input  NREQ  per-requester display mode: 0 = hex, low 32 bits used; 1 = raw segment bytes.
REQ-008 The block SHALL have port req_ready  output  NREQ  one-hot frame-accept strobe.
REQ-009 The block SHALL have port dwell_cycles  input  DWELL_W  minimum number of clk cycles a frame is held; it is sampled at accept.
REQ-010 The block SHALL have port disp_data  output  64  frame driven to the 7-segment driver.
REQ-011 The block SHALL have port disp_mode  output  1  mode driven to the 7-segment driver.
REQ-012 The block SHALL have port disp_owner  output  2  index of the requester currently shown.
REQ-013 The block SHALL have port busy  output  1  high while in the SHOW state.

Function
REQ-014 The FSM SHALL have two states, IDLE and SHOW, with IDLE as the reset state.
REQ-015 In IDLE, the block SHALL assert req_ready combinationally, same cycle, only for the round-robin winner among the set req_valid bits; at most one bit of req_ready SHALL be high.
REQ-016 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; on the next edge the block SHALL load disp_data, disp_mode and disp_owner, load the dwell counter, and enter SHOW (latency 1 cycle).
REQ-017 Round-robin search SHALL begin at (last winner + 1) mod 4; the last-winner pointer SHALL update only on a transfer.
REQ-018 In SHOW, req_ready SHALL be 0, except as allowed by REQ-021, and the counter SHALL decrement by one each cycle.
REQ-019 When the counter equals 1 in SHOW, the block SHALL return to IDLE on the next edge; disp_data and disp_mode SHALL hold their last values in IDLE (no blanking).
REQ-020 A dwell_cycles value of 0 SHALL be treated as 1, so SHOW always lasts at least 1 cycle.
REQ-021 Requester 0 is urgent: if req_valid[0] is high in SHOW and disp_owner is not 0, req_ready[0] SHALL assert and the transfer SHALL restart SHOW with requester 0's frame and a freshly loaded counter.
REQ-022 A requester's valid SHALL stay asserted until accepted; the block SHALL NOT require valid to drop after ready.
REQ-023 If the counter reaches 1 in the same cycle as an urgent preemption, the preemption SHALL take effect (stay in SHOW with requester 0).
REQ-024 disp_data, disp_mode, disp_owner and busy SHALL be registered outputs.

Reset
REQ-025 On rstn low, the block SHALL set, asynchronously: state = IDLE; disp_data = 0; disp_mode = 0; disp_owner = 0; busy = 0; counter = 0; last-winner pointer = 3, so requester 0 wins first.
REQ-026 A reset asserted during SHOW SHALL abandon the frame; after release the block SHALL re-arbitrate from requester 0.
REQ-027 req_ready SHALL be 0 whenever rstn is low.

Structure
REQ-028 Package seg_disp_pkg SHALL hold NREQ, DATA_W = 64, the state enum {IDLE, SHOW} and the mode constants MODE_HEX = 0 and MODE_RAW = 1.
REQ-029 Round-robin selection SHALL be a sub-module rr_arb4: inputs req[3:0] and last[1:0], outputs grant one-hot, grant_idx and any.
REQ-030 The estimated size is 150-250 lines of RTL including rr_arb4.

Verification
REQ-031 Reset behaviour: release reset with req_valid = 4'b0000 -> disp_data = 0, busy = 0, req_ready = 0 for 10 cycles.
REQ-032 Single requester: req_valid = 4'b0100, req_data[191:128] = 64'h1234, dwell = 5 -> req_ready = 4'b0100 for 1 cycle; next cycle disp_data = 64'h1234, owner = 2; busy high for exactly 5 cycles.
REQ-033 Round-robin fairness: all four valid continuously, dwell = 2 -> grant order 0, 1, 2, 3, 0.
REQ-034 Urgent preemption: requester 2 showing with dwell = 100; req_valid[0] raised at cycle 10 of SHOW -> req_ready = 4'b0001 that cycle; next cycle owner = 0 and the counter is reloaded.
REQ-035 Zero dwell: dwell = 0 with requester 1 valid -> SHOW lasts 1 cycle; a back-to-back re-grant occurs after a single IDLE cycle.
REQ-036 Reset mid-SHOW: assert rstn low mid-SHOW -> outputs clear immediately; after release with 4'b1010 valid, requester 1 wins first.
